// File: rtl/spi_flash_responder_if.sv
// Pin and memory-port bundle between the SoC flash initiator, the backing memory and the responder.
// master = initiator/memory side, slave = responder side.
interface spi_flash_responder_if;
  logic        flash_clk;
  logic        flash_csn;
  logic        flash_io0;
  logic        flash_io1_out;
  logic        flash_io1_en;
  logic        mem_rd_en;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        busy;

  modport master (
    output flash_clk, flash_csn, flash_io0, mem_rd_data,
    input  flash_io1_out, flash_io1_en, mem_rd_en, mem_addr, busy
  );

  modport slave (
    input  flash_clk, flash_csn, flash_io0, mem_rd_data,
    output flash_io1_out, flash_io1_en, mem_rd_en, mem_addr, busy
  );
endinterface

// File: rtl/spi_flash_responder.sv
// Single-I/O SPI flash target (mode 0) answering READ/JEDEC-ID/power-down from a byte read port.
// Define SPI_FLASH_FASTREAD_EN to also accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_flash_responder_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, JEDEC, IGNORE, PD} state_t;

  state_t      r_state;
  logic [2:0]  r_clk_sync;   // [1:0] synchronizer, [2] delayed copy for edge detect
  logic [2:0]  r_csn_sync;
  logic [1:0]  r_io0_sync;
  logic [4:0]  r_bit_cnt;
  logic [23:0] r_shift_in;
  logic [23:0] r_tx;
  logic [23:0] r_mem_addr;
  logic        r_mem_rd_en;
  logic        r_rd_d;
  logic        r_io1_out;
  logic        r_io1_en;
  logic        r_busy;
  logic        r_pd;
  logic        r_pd_arm;
  logic        r_fast;

  logic        w_rise;
  logic        w_fall;
  logic        w_csn_fall;
  logic        w_csn_rise;
  logic [23:0] w_shift;

  assign w_rise     = r_clk_sync[1] & ~r_clk_sync[2];
  assign w_fall     = ~r_clk_sync[1] & r_clk_sync[2];
  assign w_csn_fall = ~r_csn_sync[1] & r_csn_sync[2];
  assign w_csn_rise = r_csn_sync[1] & ~r_csn_sync[2];
  assign w_shift    = {r_shift_in[22:0], r_io0_sync[1]};

  assign bus.flash_io1_out = r_io1_out;
  assign bus.flash_io1_en  = r_io1_en;
  assign bus.mem_rd_en     = r_mem_rd_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.busy          = r_busy;

  // csn chain resets low so a csn already low at reset release is never seen as a fresh falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '0;
      r_csn_sync <= '0;
      r_io0_sync <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], bus.flash_clk};
      r_csn_sync <= {r_csn_sync[1:0], bus.flash_csn};
      r_io0_sync <= {r_io0_sync[0], bus.flash_io0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_tx        <= '0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
      r_rd_d      <= 1'b0;
      r_io1_out   <= 1'b0;
      r_io1_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_pd        <= 1'b0;
      r_pd_arm    <= 1'b0;
      r_fast      <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_rd_d      <= r_mem_rd_en;
      if (w_csn_rise) begin
        r_state   <= (r_pd | r_pd_arm) ? PD : IDLE;
        r_pd      <= r_pd | r_pd_arm;
        r_pd_arm  <= 1'b0;
        r_rd_d    <= 1'b0;
        r_io1_out <= 1'b0;
        r_io1_en  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE, PD: begin
            if (w_csn_fall) begin
              r_state   <= CMD;
              r_bit_cnt <= '0;
              r_busy    <= 1'b1;
              r_fast    <= 1'b0;
            end
          end
          CMD: begin
            if (w_rise) begin
              r_shift_in <= w_shift;
              r_bit_cnt  <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                if (r_pd && w_shift[7:0] != 8'hAB) begin
                  r_state <= IGNORE;
                end else begin
                  case (w_shift[7:0])
                    8'h03: r_state <= ADDR;
`ifdef SPI_FLASH_FASTREAD_EN
                    8'h0B: begin
                      r_state <= ADDR;
                      r_fast  <= 1'b1;
                    end
`endif
                    8'h9F: begin
                      r_state  <= JEDEC;
                      r_tx     <= JEDEC_ID;
                      r_io1_en <= 1'b1;
                    end
                    8'hB9: begin
                      r_state  <= IGNORE;
                      r_pd_arm <= 1'b1;
                    end
                    8'hAB: begin
                      r_state <= IGNORE;
                      r_pd    <= 1'b0;
                    end
                    default: r_state <= IGNORE;
                  endcase
                end
              end
            end
          end
          ADDR: begin
            if (w_rise) begin
              r_shift_in <= w_shift;
              r_bit_cnt  <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt  <= '0;
                r_mem_addr <= w_shift;
                if (r_fast) begin
                  r_state <= DUMMY;
                end else begin
                  r_state     <= DATA;
                  r_mem_rd_en <= 1'b1;
                end
              end
            end
          end
          DUMMY: begin
            if (w_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt   <= '0;
                r_state     <= DATA;
                r_mem_rd_en <= 1'b1;
              end
            end
          end
          DATA: begin
            // Read data is valid the cycle after the strobe, so capture two clocks after issuing it.
            if (r_rd_d) begin
              r_tx     <= {bus.mem_rd_data, 16'h0000};
              r_io1_en <= 1'b1;
            end else if (w_fall) begin
              r_io1_out <= r_tx[23];
              r_tx      <= {r_tx[22:0], 1'b0};
            end
            if (w_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt[2:0] == 3'd7) begin
                r_mem_addr  <= r_mem_addr + 24'd1;
                r_mem_rd_en <= 1'b1;
              end
            end
          end
          JEDEC: begin
            // Zeros shift in behind the ID, so the line reads 0 once the ID is exhausted.
            if (w_fall) begin
              r_io1_out <= r_tx[23];
              r_tx      <= {r_tx[22:0], 1'b0};
            end
          end
          IGNORE: begin
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: an SPI initiator model plus a byte memory model,
// checked against expected responses derived from the command set.
module tb_spi_flash_responder;
  localparam int          HALF   = 5;
  localparam logic [23:0] JEDEC  = 24'hEF4016;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  spi_flash_responder_if bus();

  spi_flash_responder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit model_pd = 1'b0;

  logic [23:0] rd_log [0:1023];
  int          rd_cnt = 0;
  int          en_cycles = 0;
  int          b2b_cnt = 0;
  logic        prev_rd = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= mem_byte(bus.mem_addr);
      rd_log[rd_cnt % 1024] <= bus.mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_rd_en && prev_rd) b2b_cnt <= b2b_cnt + 1;
    prev_rd <= bus.mem_rd_en;
    if (bus.flash_io1_en) en_cycles <= en_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input bit mosi, output bit miso);
    bus.flash_io0 = mosi;
    repeat (HALF) @(negedge clk);
    miso = bus.flash_io1_out;
    bus.flash_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.flash_clk = 1'b0;
  endtask

  // abort_at > 0 raises csn after that many bits, always before the command/address/dummy phase ends.
  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                         input int abort_at);
    bit          is_read, is_fast, answered, full, miso, mosi;
    int          lead, total, rd_base, en_base, nrd, exp_rd;
    logic [7:0]  got [0:7];
    logic [7:0]  exp_b;
    logic [23:0] id;
    id      = JEDEC;
`ifdef SPI_FLASH_FASTREAD_EN
    is_fast = (cmd == 8'h0B);
`else
    is_fast = 1'b0;
`endif
    is_read  = (cmd == 8'h03) || is_fast;
    answered = !model_pd && (is_read || cmd == 8'h9F);
    lead     = 8 + (is_read ? 24 : 0) + (is_fast ? 8 : 0);
    total    = (abort_at > 0) ? abort_at : lead + 8 * nbytes;
    full     = (abort_at == 0);
    for (int k = 0; k < 8; k++) got[k] = 8'h00;
    $display("txn cmd=%h addr=%h bytes=%0d abort=%0d pd=%0d", cmd, addr, nbytes, abort_at, model_pd);

    rd_base = rd_cnt;
    en_base = en_cycles;
    bus.flash_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < total; i++) begin
      if (i < 8)                  mosi = cmd[7 - i];
      else if (is_read && i < 32) mosi = addr[31 - i];
      else                        mosi = 1'($urandom());
      spi_bit(mosi, miso);
      if (i == 0) check("busy_during", {31'd0, bus.busy}, 32'd1);
      if (i >= lead) got[(i - lead) / 8] = {got[(i - lead) / 8][6:0], miso};
    end
    repeat (2) @(negedge clk);
    bus.flash_csn = 1'b1;
    repeat (4) @(negedge clk);
    check("en_after_csn", {31'd0, bus.flash_io1_en}, 32'd0);
    check("busy_after_csn", {31'd0, bus.busy}, 32'd0);
    repeat (6) @(negedge clk);

    if (answered && full) begin
      for (int k = 0; k < nbytes; k++) begin
        if (is_read) exp_b = mem_byte(addr + 24'(k));
        else         exp_b = (k < 3) ? id[23 - 8 * k -: 8] : 8'h00;
        check($sformatf("byte%0d", k), {24'd0, got[k]}, {24'd0, exp_b});
      end
    end
    // Every byte is fetched by its own strobe, including one prefetch after the last byte clocked.
    exp_rd = (answered && full && is_read) ? nbytes + 1 : 0;
    nrd    = rd_cnt - rd_base;
    check("read_count", nrd, exp_rd);
    for (int k = 0; k < exp_rd && k < nrd; k++)
      check($sformatf("read_addr%0d", k), {8'd0, rd_log[(rd_base + k) % 1024]},
            {8'd0, addr + 24'(k)});
    check("en_seen", {31'd0, (en_cycles != en_base)}, {31'd0, answered && full});

    if (full && cmd == 8'hAB)      model_pd = 1'b0;
    else if (full && cmd == 8'hB9) model_pd = 1'b1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          dummy;
    int          pick, nb, ab, lead;
    logic [7:0]  cmd;
    logic [23:0] addr;

    bus.flash_clk   = 1'b0;
    bus.flash_csn   = 1'b1;
    bus.flash_io0   = 1'b0;
    bus.mem_rd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_io1_out", {31'd0, bus.flash_io1_out}, 32'd0);
    check("rst_io1_en", {31'd0, bus.flash_io1_en}, 32'd0);
    check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("rst_addr", {8'd0, bus.mem_addr}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);

    run_txn(8'h9F, 24'h0, 3, 0);
    run_txn(8'h03, 24'h000100, 4, 0);
    run_txn(8'h03, 24'hFFFFFE, 4, 0);
    run_txn(8'h03, 24'h123456, 2, 18);
    run_txn(8'h9F, 24'h0, 3, 0);
    run_txn(8'hB9, 24'h0, 1, 0);
    run_txn(8'h9F, 24'h0, 3, 0);
    run_txn(8'h03, 24'h000010, 2, 0);
    run_txn(8'hAB, 24'h0, 1, 0);
    run_txn(8'h9F, 24'h0, 4, 0);

    // Reset in the middle of the second data byte, then keep clocking with csn still low.
    $display("txn reset during read");
    bus.flash_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    addr = 24'h000200;
    for (int i = 0; i < 44; i++)
      spi_bit((i < 8) ? cmd_bit(8'h03, i) : (i < 32) ? addr[31 - i] : 1'b0, dummy);
    reset_n = 1'b0;
    #1;
    check("mid_rst_io1_out", {31'd0, bus.flash_io1_out}, 32'd0);
    check("mid_rst_io1_en", {31'd0, bus.flash_io1_en}, 32'd0);
    check("mid_rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("mid_rst_addr", {8'd0, bus.mem_addr}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_pd = 1'b0;
    pick = rd_cnt;
    nb   = en_cycles;
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom()), dummy);
    check("post_rst_reads", rd_cnt - pick, 0);
    check("post_rst_en", en_cycles - nb, 0);
    bus.flash_csn = 1'b1;
    repeat (10) @(negedge clk);
    run_txn(8'h03, 24'h000000, 1, 0);

    for (int t = 0; t < 40; t++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0, 1:    cmd = 8'h03;
        2:       cmd = 8'h9F;
        3:       cmd = 8'hB9;
        4:       cmd = 8'hAB;
        5:       cmd = 8'h0B;
        default: cmd = 8'($urandom());
      endcase
      addr = ($urandom_range(0, 1) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom());
      nb   = $urandom_range(1, 5);
      lead = 8;
      if (cmd == 8'h03) lead = 32;
`ifdef SPI_FLASH_FASTREAD_EN
      if (cmd == 8'h0B) lead = 40;
`endif
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lead - 1) : 0;
      run_txn(cmd, addr, nb, ab);
    end

    check("no_b2b_rd_en", b2b_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  function automatic bit cmd_bit(input logic [7:0] c, input int i);
    return c[7 - i];
  endfunction
endmodule
